// File: rtl/pin_scatter_seq.sv
// pin_scatter_seq: multi-cycle bit scatter (decompress) / gather (compress)
// engine. Walks the captured mask LANES positions per cycle and keeps a
// running rank pointer that says which packed bit is next.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// RUN   | walking the mask, one chunk of LANES positions per cycle
// DONE  | result and count presented, waiting for out_ready
module pin_scatter_seq #(
  parameter int WIDTH = 16,
  parameter int LANES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       mode,
  input  logic [WIDTH-1:0]           data,
  input  logic [WIDTH-1:0]           mask,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           result,
  output logic [$clog2(WIDTH+1)-1:0] count
);

  localparam int N  = (WIDTH + LANES - 1) / LANES;
  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = $clog2(N * LANES + 1);
  localparam int NW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [WIDTH-1:0]  mask_q, mask_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [CW-1:0]     rank_q, rank_d;
  logic [PW-1:0]     base_q, base_d;
  logic [NW-1:0]     cnt_q, cnt_d;

  logic [CW-1:0]     rank_v;
  logic [PW-1:0]     pos_v;
  logic              mbit;
  logic              dbit;

  // Next-state and datapath: capture on accept, process one chunk per RUN cycle.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    data_d  = data_q;
    mask_d  = mask_q;
    acc_d   = acc_q;
    rank_d  = rank_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    rank_v  = rank_q;
    pos_v   = base_q;
    mbit    = 1'b0;
    dbit    = 1'b0;

    if (clear) begin
      // Abort wins over both accept and output handshake.
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            state_d = RUN;
            mode_d  = mode;
            data_d  = data;
            mask_d  = mask;
            acc_d   = '0;
            rank_d  = '0;
            base_d  = '0;
            cnt_d   = NW'(N - 1);
          end
        end
        RUN: begin
          // Positions past WIDTH shift the mask to zero, so a partial last
          // chunk needs no special casing.
          for (int l = 0; l < LANES; l++) begin
            pos_v = base_q + PW'(l);
            mbit  = ((mask_q >> pos_v) & WIDTH'(1)) != '0;
            if (mbit) begin
              if (mode_q) begin
                dbit  = ((data_q >> pos_v) & WIDTH'(1)) != '0;
                acc_d = acc_d | (WIDTH'(dbit) << rank_v);
              end else begin
                dbit  = ((data_q >> rank_v) & WIDTH'(1)) != '0;
                acc_d = acc_d | (WIDTH'(dbit) << pos_v);
              end
              rank_v = rank_v + CW'(1);
            end
          end
          rank_d = rank_v;
          base_d = base_q + PW'(LANES);
          if (cnt_q == '0) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - NW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
      acc_q   <= '0;
      rank_q  <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      acc_q   <= acc_d;
      rank_q  <= rank_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end

  // Final rank equals the mask popcount, so it doubles as the count output.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = acc_q;
  assign count     = rank_q;

endmodule
